// File: rtl/uart_mem_master.sv
// uart_mem_master: 8N1 UART command decoder that issues single 32-bit reads/writes on a valid/ready bus
// and returns 'K' for writes or the four read data bytes (LSB first) for reads.
module uart_mem_master #(
    parameter int CLK_DIV = 868,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] IDLE_END = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    rx_state_t     rx_state_q;
    logic          rx_meta_q, rx_sync_q, rx_strobe_q;
    logic [CW-1:0] rx_cnt_q;
    logic [2:0]    rx_bit_q;
    logic [7:0]    rx_byte_q;

    logic          tx_active_q;
    logic [CW-1:0] tx_cnt_q;
    logic [3:0]    tx_left_q;
    logic [8:0]    tx_sh_q;

    state_t        state_q;
    logic          op_w_q;
    logic [1:0]    byte_cnt_q;
    logic [2:0]    resp_left_q;
    logic [31:0]   rdata_q;
    logic [TW-1:0] idle_cnt_q;

    logic tx_tick, tx_ready, tx_load;
    logic [7:0] tx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_strobe_q <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_byte_q   <= '0;
        end else begin
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_strobe_q <= 1'b0;
            rx_cnt_q    <= rx_cnt_q + 1'b1;
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (!rx_sync_q) rx_state_q <= RX_START;
                end
                // mid-start recheck rejects glitches shorter than half a bit
                RX_START: if (rx_cnt_q == HALF_END) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_cnt_q == BIT_END) begin
                    rx_cnt_q  <= '0;
                    rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                    rx_bit_q  <= rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                end
                RX_STOP: if (rx_cnt_q == BIT_END) begin
                    rx_strobe_q <= rx_sync_q;
                    rx_state_q  <= rx_sync_q ? RX_IDLE : RX_WAIT;
                end
                default: if (rx_sync_q) rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // a new byte may load on the final tick of the previous stop bit so bytes go out back-to-back
    assign tx_tick  = tx_cnt_q == BIT_END;
    assign tx_ready = !tx_active_q || (tx_tick && tx_left_q == '0);
    assign tx_load  = state_q == RESP && resp_left_q != '0 && tx_ready;
    assign tx_byte  = op_w_q ? 8'h4B : rdata_q[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uart_tx     <= 1'b1;
            tx_active_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_left_q   <= '0;
            tx_sh_q     <= '1;
        end else if (tx_load) begin
            uart_tx     <= 1'b0;
            tx_active_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_left_q   <= 4'd9;
            tx_sh_q     <= {1'b1, tx_byte};
        end else if (tx_active_q) begin
            tx_cnt_q <= tx_tick ? '0 : tx_cnt_q + 1'b1;
            if (tx_tick && tx_left_q == '0) begin
                tx_active_q <= 1'b0;
            end else if (tx_tick) begin
                uart_tx   <= tx_sh_q[0];
                tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
                tx_left_q <= tx_left_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_w_q      <= 1'b0;
            byte_cnt_q  <= '0;
            resp_left_q <= '0;
            rdata_q     <= '0;
            idle_cnt_q  <= '0;
            busy        <= 1'b0;
            mem_valid   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
        end else begin
            if (tx_load) begin
                resp_left_q <= resp_left_q - 1'b1;
                rdata_q     <= rdata_q >> 8;
            end
            case (state_q)
                IDLE: if (rx_strobe_q && (rx_byte_q == 8'h57 || rx_byte_q == 8'h52)) begin
                    op_w_q     <= rx_byte_q == 8'h57;
                    byte_cnt_q <= '0;
                    idle_cnt_q <= '0;
                    busy       <= 1'b1;
                    state_q    <= ADDR;
                end
                ADDR, DATA: begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                    if (rx_strobe_q) begin
                        idle_cnt_q <= '0;
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        if (state_q == ADDR) mem_addr[8*byte_cnt_q +: 8] <= rx_byte_q;
                        else mem_wdata[8*byte_cnt_q +: 8] <= rx_byte_q;
                        if (byte_cnt_q == 2'd3) state_q <= (state_q == ADDR && op_w_q) ? DATA : BUS;
                    end else if (idle_cnt_q == IDLE_END) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                BUS: if (!mem_valid) begin
                    mem_valid <= 1'b1;
                    mem_wstrb <= {4{op_w_q}};
                end else if (mem_ready) begin
                    mem_valid   <= 1'b0;
                    mem_wstrb   <= '0;
                    resp_left_q <= op_w_q ? 3'd1 : 3'd4;
                    if (!op_w_q) rdata_q <= mem_rdata;
                    state_q     <= RESP;
                end
                default: if (!tx_active_q && resp_left_q == '0) begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
